// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch controller: FSM states, the
// {pc, inst, adel} result record and its reset value.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } if_out_t;

  localparam if_out_t IF_OUT_RST = '{pc: 32'h0, inst: 32'h0, adel: 1'b0};

  // Instructions are word aligned; any low address bit set is an address error.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry hold buffer in front of the IF/ID-facing output register.
// A result arriving while downstream is stalled parks in the buffer and
// moves to the output register on the first unstalled cycle.
module if_hold_buf
  import if_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  if_out_t load_data,
  input  logic    stall,
  input  logic    flush,
  output if_out_t out_data,
  output logic    out_valid
);

  if_out_t buf_data;
  logic    buf_full;

  // Output register and buffer: flush kills both, stall freezes the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= IF_OUT_RST;
      out_valid <= 1'b0;
      buf_data  <= IF_OUT_RST;
      buf_full  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      buf_full  <= 1'b0;
    end else if (stall) begin
      if (load) begin
        buf_data <= load_data;
        buf_full <= 1'b1;
      end
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (buf_full) begin
      out_data  <= buf_data;
      out_valid <= 1'b1;
      buf_full  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: one instruction-bus transaction per PC,
// result delivered through a stall-tolerant output register.
//
// state | meaning
// IDLE  | no transaction; accepts the PC presented by the PC register
// REQ   | inst_req_o high, address held until the bus accepts it
// WAIT  | address accepted, waiting for read data
// HOLD  | result parked in the hold buffer while downstream is stalled
//
// kill marks an in-flight transaction whose data must be discarded
// because a flush arrived after the request was issued.
module inst_fetch_ctrl
  import if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        adel_o,
  output logic        stallreq_o
);

  fetch_state_t state;
  logic         kill;
  logic         pc_bad;
  logic         fetch_go;
  logic         res_adel;
  logic         res_data;
  logic         res_valid;
  if_out_t      res;
  if_out_t      out_data;

  assign pc_bad   = is_misaligned(pc_i);
  assign fetch_go = (state == IDLE) & ce_i & ~flush_i;
  assign res_adel = fetch_go & pc_bad;
  assign res_data = (state == WAIT) & inst_data_ok_i & ~kill & ~flush_i;
  assign res_valid = res_adel | res_data;

  // Result record: address-error results never touch the bus.
  always_comb begin
    res = IF_OUT_RST;
    if (res_adel) begin
      res.pc   = pc_i;
      res.inst = 32'h0;
      res.adel = 1'b1;
    end else if (res_data) begin
      res.pc   = inst_addr_o;
      res.inst = inst_rdata_i;
      res.adel = 1'b0;
    end
  end

  // Hold the PC while its fetch is unresolved; release it in the cycle the
  // result is produced, and during a flush so the redirect target loads.
  assign stallreq_o = ce_i & ~flush_i
                    & (state != HOLD)
                    & ~((state == IDLE) & pc_bad)
                    & ~((state == WAIT) & inst_data_ok_i & ~kill);

  // Fetch sequencing, bus request/address registers and the kill flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      kill        <= 1'b0;
      inst_req_o  <= 1'b0;
      inst_addr_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_go) begin
            if (pc_bad) begin
              state <= stall_i ? HOLD : IDLE;
            end else begin
              inst_addr_o <= pc_i;
              inst_req_o  <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // The request stays up through a flush; only its data is dropped.
          if (flush_i) begin
            kill <= 1'b1;
          end
          if (inst_addr_ok_i) begin
            inst_req_o <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (inst_data_ok_i) begin
            kill <= 1'b0;
            if (kill | flush_i) begin
              state <= IDLE;
            end else begin
              state <= stall_i ? HOLD : IDLE;
            end
          end else if (flush_i) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (flush_i | ~stall_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_hold_buf u_hold_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (res_valid),
    .load_data (res),
    .stall     (stall_i),
    .flush     (flush_i),
    .out_data  (out_data),
    .out_valid (valid_o)
  );

  assign pc_o   = out_data.pc;
  assign inst_o = out_data.inst;
  assign adel_o = out_data.adel;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: table of single-fetch vectors, hand-written
// stall/flush/reset sequences, and a randomized run against a PC-register
// and instruction-memory model.
module tb_inst_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        stall_i;
  logic        flush_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        adel_o;
  logic        stallreq_o;

  inst_fetch_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_i           (pc_i),
    .ce_i           (ce_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .valid_o        (valid_o),
    .adel_o         (adel_o),
    .stallreq_o     (stallreq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h3C01_0001;
      32'hBFC0_0100: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[31:16]};
    endcase
  endfunction

  // Bus slave model state.
  bit          acc_pending = 0;
  logic [31:0] acc_addr = '0;
  int          req_age = 0;
  int          data_age = 0;
  int          a_dly = 0;
  int          d_dly = 0;
  bit          rand_bus = 0;
  bit          spurious_en = 0;
  bit          req_open = 0;
  logic [31:0] req_addr = '0;

  task automatic drive_bus();
    inst_addr_ok_i = inst_req_o && !acc_pending && (req_age >= a_dly);
    if (acc_pending && data_age >= d_dly) begin
      inst_data_ok_i = 1'b1;
      inst_rdata_i   = mem_word(acc_addr);
    end else begin
      inst_data_ok_i = spurious_en && !acc_pending && ($urandom_range(0, 7) == 0);
      inst_rdata_i   = $urandom;
    end
    #1;
  endtask

  task automatic commit_bus();
    if (rst_i) begin
      acc_pending = 0;
      req_age = 0;
      data_age = 0;
      req_open = 0;
      return;
    end
    if (inst_req_o) check("one_outstanding", 32'(acc_pending), 32'd0);
    if (req_open && inst_req_o) check("addr_stable", inst_addr_o, req_addr);
    req_open = inst_req_o && !inst_addr_ok_i;
    req_addr = inst_addr_o;
    if (acc_pending) begin
      if (inst_data_ok_i) acc_pending = 0;
      else data_age++;
    end else if (inst_req_o) begin
      if (inst_addr_ok_i) begin
        acc_pending = 1;
        acc_addr = inst_addr_o;
        data_age = 0;
        req_age = 0;
        if (rand_bus) begin
          a_dly = $urandom_range(0, 3);
          d_dly = $urandom_range(0, 3);
        end
      end else begin
        req_age++;
      end
    end
  endtask

  task automatic end_cycle();
    commit_bus();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    ce_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    pc_i = 32'h0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    inst_rdata_i = 32'h0;
    #1;
    repeat (2) end_cycle();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          a;
    int          d;
    int          lat;
    logic        req;
    logic [31:0] inst;
    logic        adel;
  } vec_t;

  vec_t vecs[6];

  // Random-phase reference state.
  logic [31:0] pc_reg;
  logic [31:0] target;
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        exp_adel;
  logic        consumed;
  int          stall_run;
  int          deliveries;

  initial begin
    vecs[0] = '{pc: 32'hBFC0_0000, a: 0, d: 0, lat: 3, req: 1'b1, inst: 32'h3C01_0001, adel: 1'b0};
    vecs[1] = '{pc: 32'h8000_1000, a: 3, d: 2, lat: 8, req: 1'b1, inst: 32'h1000_7FFF, adel: 1'b0};
    vecs[2] = '{pc: 32'hBFC0_0002, a: 0, d: 0, lat: 1, req: 1'b0, inst: 32'h0,         adel: 1'b1};
    vecs[3] = '{pc: 32'h0000_0003, a: 0, d: 0, lat: 1, req: 1'b0, inst: 32'h0,         adel: 1'b1};
    vecs[4] = '{pc: 32'h1234_5678, a: 1, d: 0, lat: 4, req: 1'b1, inst: 32'h5678_EDCB, adel: 1'b0};
    vecs[5] = '{pc: 32'hFFFF_FFFC, a: 0, d: 4, lat: 7, req: 1'b1, inst: 32'hFFFC_0000, adel: 1'b0};

    @(negedge clk_i);
    do_reset();
    check("rst_req",   32'(inst_req_o), 32'd0);
    check("rst_addr",  inst_addr_o,     32'h0);
    check("rst_pc",    pc_o,            32'h0);
    check("rst_inst",  inst_o,          32'h0);
    check("rst_valid", 32'(valid_o),    32'd0);
    check("rst_adel",  32'(adel_o),     32'd0);

    // Table-driven single fetches.
    foreach (vecs[i]) begin
      int  got;
      bit  seen_req;
      do_reset();
      rand_bus = 0;
      spurious_en = 0;
      a_dly = vecs[i].a;
      d_dly = vecs[i].d;
      pc_i = vecs[i].pc;
      ce_i = 1'b1;
      got = -1;
      seen_req = 0;
      for (int c = 0; c < 20; c++) begin
        if (valid_o === 1'b1) begin
          got = c;
          break;
        end
        if (inst_req_o) begin
          seen_req = 1;
          check("vec_req_addr", inst_addr_o, vecs[i].pc);
        end
        if (c == 1) check("vec_req_cycle1", 32'(inst_req_o), 32'(vecs[i].req));
        drive_bus();
        check("vec_stallreq", 32'(stallreq_o), (c < vecs[i].lat - 1) ? 32'd1 : 32'd0);
        end_cycle();
      end
      check("vec_latency", 32'(got), 32'(vecs[i].lat));
      check("vec_pc", pc_o, vecs[i].pc);
      check("vec_inst", inst_o, vecs[i].inst);
      check("vec_adel", 32'(adel_o), 32'(vecs[i].adel));
      check("vec_req_seen", 32'(seen_req), 32'(vecs[i].req));
      ce_i = 1'b0;
      drive_bus();
      end_cycle();
      check("vec_single_pulse", 32'(valid_o), 32'd0);
    end

    // Downstream stall covering the data_ok cycle.
    do_reset();
    a_dly = 0;
    d_dly = 0;
    for (int c = 0; c <= 9; c++) begin
      if (c == 3) begin
        check("hold_first_valid", 32'(valid_o), 32'd1);
        check("hold_first_pc", pc_o, 32'h8000_1000);
      end
      if (c >= 4 && c <= 7) begin
        check("hold_out_valid", 32'(valid_o), 32'd1);
        check("hold_out_pc", pc_o, 32'h8000_1000);
        check("hold_out_inst", inst_o, 32'h1000_7FFF);
      end
      if (c == 8) begin
        check("hold_rel_valid", 32'(valid_o), 32'd1);
        check("hold_rel_pc", pc_o, 32'hBFC0_0000);
        check("hold_rel_inst", inst_o, 32'h3C01_0001);
      end
      if (c == 9) check("hold_once", 32'(valid_o), 32'd0);
      stall_i = (c >= 3 && c <= 6);
      ce_i = (c <= 7);
      pc_i = (c < 3) ? 32'h8000_1000 : 32'hBFC0_0000;
      drive_bus();
      if (c == 6 || c == 7) check("hold_stallreq", 32'(stallreq_o), 32'd0);
      end_cycle();
    end
    stall_i = 1'b0;

    // Flush while waiting for data; the killed word must never appear.
    do_reset();
    a_dly = 0;
    d_dly = 3;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 4 && c <= 8) check("flush_no_valid", 32'(valid_o), 32'd0);
      if (valid_o) check("flush_not_dead", 32'(inst_o == 32'hDEAD_BEEF), 32'd0);
      if (c == 7) begin
        check("flush_new_req", 32'(inst_req_o), 32'd1);
        check("flush_new_addr", inst_addr_o, 32'hBFC0_0380);
      end
      if (c == 9) begin
        check("flush_new_valid", 32'(valid_o), 32'd1);
        check("flush_new_pc", pc_o, 32'hBFC0_0380);
        check("flush_new_inst", inst_o, 32'h0380_403F);
      end
      if (c == 10) check("flush_once", 32'(valid_o), 32'd0);
      flush_i = (c == 3);
      ce_i = (c <= 8);
      pc_i = (c < 4) ? 32'hBFC0_0100 : 32'hBFC0_0380;
      if (c == 6) d_dly = 0;
      drive_bus();
      if (c == 3) check("flush_stallreq_low", 32'(stallreq_o), 32'd0);
      if (c == 4 || c == 5) check("flush_drain_stallreq", 32'(stallreq_o), 32'd1);
      end_cycle();
    end
    flush_i = 1'b0;

    // Reset in the middle of a transaction.
    do_reset();
    a_dly = 0;
    d_dly = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 3) check("rstw_prev_valid", 32'(valid_o), 32'd1);
      if (c == 6) check("rstw_in_wait_addr", inst_addr_o, 32'hBFC0_0000);
      if (c == 7) begin
        check("rstw_req",   32'(inst_req_o), 32'd0);
        check("rstw_addr",  inst_addr_o,     32'h0);
        check("rstw_pc",    pc_o,            32'h0);
        check("rstw_inst",  inst_o,          32'h0);
        check("rstw_valid", 32'(valid_o),    32'd0);
        check("rstw_adel",  32'(adel_o),     32'd0);
      end
      if (c >= 8) begin
        check("rstw_ignore_valid", 32'(valid_o), 32'd0);
        check("rstw_ignore_req", 32'(inst_req_o), 32'd0);
      end
      if (c == 3) d_dly = 5;
      rst_i = (c == 6);
      ce_i = (c < 6);
      pc_i = (c < 3) ? 32'h8000_1000 : 32'hBFC0_0000;
      drive_bus();
      if (c >= 7 && c <= 9) begin
        inst_data_ok_i = 1'b1;
        inst_rdata_i = 32'hCAFE_F00D;
        #1;
        check("rstw_stallreq", 32'(stallreq_o), 32'd0);
      end
      end_cycle();
    end

    // Randomized run: every PC the PC register steps past must be
    // delivered in the following cycle, in order, with memory contents.
    do_reset();
    rand_bus = 1;
    spurious_en = 1;
    a_dly = $urandom_range(0, 3);
    d_dly = $urandom_range(0, 3);
    pc_reg = 32'hBFC0_0000;
    exp_valid = 1'b0;
    exp_pc = '0;
    exp_inst = '0;
    exp_adel = 1'b0;
    stall_run = 0;
    deliveries = 0;
    for (int c = 0; c < 4000; c++) begin
      check("rand_valid", 32'(valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check("rand_pc", pc_o, exp_pc);
        check("rand_inst", inst_o, exp_inst);
        check("rand_adel", 32'(adel_o), 32'(exp_adel));
      end
      ce_i = 1'b1;
      stall_i = ($urandom_range(0, 99) < 25);
      flush_i = ($urandom_range(0, 99) < 6);
      target = $urandom;
      target[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pc_i = pc_reg;
      drive_bus();
      if (stallreq_o) stall_run++;
      else stall_run = 0;
      if (stall_run > 60) begin
        check("rand_stallreq_bound", 32'(stall_run), 32'd60);
        stall_run = 0;
      end
      consumed = ce_i & ~flush_i & ~stallreq_o & ~stall_i;
      if (consumed) begin
        exp_valid = 1'b1;
        exp_pc = pc_reg;
        exp_adel = (pc_reg[1:0] != 2'b00);
        exp_inst = exp_adel ? 32'h0 : mem_word(pc_reg);
        deliveries++;
      end else if (flush_i || !stall_i) begin
        exp_valid = 1'b0;
      end
      if (flush_i) pc_reg = target;
      else if (consumed) pc_reg = pc_reg + 32'd4;
      end_cycle();
    end
    check("rand_progress", 32'(deliveries > 200), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
